// File: rtl/io_read_port_buffer_pkg.sv
// io_read_port_buffer_pkg
//   Shared constants and helpers for the Datapath I/O read port buffer.
//   - DEFAULT_WORD_WIDTH : default Datapath word width.
//   - clog2_depth()      : constant function used to check the ADDR_WIDTH/DEPTH pairing
//                          at elaboration.
//   The optional occupancy output is enabled by defining IO_READ_BUFFER_COUNT_EN.

package io_read_port_buffer_pkg;

    localparam int unsigned DEFAULT_WORD_WIDTH = 36;

    // Ceiling log2; valid for value >= 1.
    function automatic int unsigned clog2_depth(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/io_read_port_buffer_if.sv
// io_read_port_buffer_if
//   Bundles the producer handshake and the Datapath read-port signals of one buffer.
//   Producer side : in_data, in_valid -> ; <- in_ready
//   Datapath side : io_rden -> ; <- io_read_EF, io_read_data, underflow
//   Modports:
//   - master : the environment (producer plus Datapath) driving the buffer.
//   - slave  : the buffer itself.

interface io_read_port_buffer_if #(
    parameter int unsigned WORD_WIDTH = io_read_port_buffer_pkg::DEFAULT_WORD_WIDTH
) ();

    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  io_read_EF;
    logic [WORD_WIDTH-1:0] io_read_data;
    logic                  io_rden;
    logic                  underflow;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  io_read_EF,
        input  io_read_data,
        output io_rden,
        input  underflow
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output io_read_EF,
        output io_read_data,
        input  io_rden,
        output underflow
    );

endinterface

// File: rtl/io_buffer_storage.sv
// io_buffer_storage
//   Register-array storage for io_read_port_buffer: one synchronous write port and one
//   asynchronous read port. Entries carry no reset; the owner masks reads of empty slots.
//   Ports:
//   - clock   : rising-edge clock.
//   - wr_en   : write wr_data into entry wr_addr at this edge.
//   - wr_addr : write entry index.
//   - wr_data : write word.
//   - rd_addr : read entry index.
//   - rd_data : contents of entry rd_addr (combinational).

module io_buffer_storage
    import io_read_port_buffer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0] rd_data
);

    logic [WORD_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/io_read_port_buffer.sv
// io_read_port_buffer
//   Elastic input buffer in front of one Datapath I/O read port. Words arrive from a
//   producer over valid/ready and are presented to the Datapath as io_read_EF/io_read_data
//   with first-word fall-through from registers; io_rden retires the head word.
//   All flags come from the registered occupancy only, so there is no combinational path
//   from in_* or io_rden to any output.
//   Ports:
//   - clock      : rising-edge clock.
//   - reset_n    : asynchronous active-low reset.
//   - fill_count : registered occupancy (only when IO_READ_BUFFER_COUNT_EN is defined).
//   - bus        : io_read_port_buffer_if.slave (producer handshake + Datapath read port).
//   Build option: define IO_READ_BUFFER_COUNT_EN to expose fill_count.

module io_read_port_buffer
    import io_read_port_buffer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
`ifdef IO_READ_BUFFER_COUNT_EN
    output logic [ADDR_WIDTH:0]     fill_count,
`endif
    io_read_port_buffer_if.slave    bus
);

    if (DEPTH < 2 || ADDR_WIDTH != clog2_depth(DEPTH) || (1 << ADDR_WIDTH) != DEPTH)
    begin : g_bad_config
        $error("io_read_port_buffer: DEPTH must be a power of two >= 2 and ADDR_WIDTH == log2(DEPTH)");
    end

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wp_q, wp_d;
    logic [ADDR_WIDTH-1:0] rp_q, rp_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  underflow_q, underflow_d;

    logic                  in_ready;
    logic                  read_ef;
    logic                  push;
    logic                  pop;
    logic [WORD_WIDTH-1:0] rd_data;

    assign in_ready = (count_q != FULL_COUNT);
    assign read_ef  = (count_q != '0);
    assign push     = bus.in_valid && in_ready;
    assign pop      = bus.io_rden && read_ef;

    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        // Pointers wrap for free because DEPTH is a power of two.
        if (push) begin
            wp_d = wp_q + PTR_ONE;
        end
        if (pop) begin
            rp_d = rp_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
        if (bus.io_rden && !read_ef) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    io_buffer_storage #(
        .WORD_WIDTH (WORD_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_storage (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wp_q),
        .wr_data (bus.in_data),
        .rd_addr (rp_q),
        .rd_data (rd_data)
    );

    assign bus.in_ready     = in_ready;
    assign bus.io_read_EF   = read_ef;
    // Storage entries are unreset, so the head is masked to zero while empty.
    assign bus.io_read_data = read_ef ? rd_data : '0;
    assign bus.underflow    = underflow_q;

`ifdef IO_READ_BUFFER_COUNT_EN
    assign fill_count = count_q;
`endif

endmodule

// File: tb/tb_io_read_port_buffer.sv
// tb_io_read_port_buffer
//   Directed bench for io_read_port_buffer. The driver pushes each accepted word onto an
//   expected queue; a negedge monitor checks flags against the queue occupancy and
//   compares every retired head word with the queue front.

module tb_io_read_port_buffer;

    localparam int unsigned W     = 36;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    io_read_port_buffer_if #(.WORD_WIDTH(W)) bus ();

`ifdef IO_READ_BUFFER_COUNT_EN
    logic [AW:0] fill_count;
`endif

    io_read_port_buffer #(
        .WORD_WIDTH (W),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
`ifdef IO_READ_BUFFER_COUNT_EN
        .fill_count (fill_count),
`endif
        .bus        (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    logic [W-1:0] exp_q[$];
    logic        exp_uf = 1'b0;
    logic        acc;
    int          sent;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Scoreboard monitor: DUT state is stable at the negedge.
    always @(negedge clock) begin
        check("mon_read_EF", 64'(bus.io_read_EF), 64'(exp_q.size() != 0));
        check("mon_in_ready", 64'(bus.in_ready), 64'(exp_q.size() != int'(DEPTH)));
        check("mon_underflow", 64'(bus.underflow), 64'(exp_uf));
        if (exp_q.size() == 0) begin
            check("mon_empty_data", 64'(bus.io_read_data), 64'(0));
        end
`ifdef IO_READ_BUFFER_COUNT_EN
        check("mon_fill_count", 64'(fill_count), 64'(exp_q.size()));
`endif
        if (bus.io_rden && bus.io_read_EF) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_pop: got pop of %0h, expected empty buffer", bus.io_read_data);
            end else begin
                check("mon_pop_data", 64'(bus.io_read_data), 64'(exp_q[0]));
                void'(exp_q.pop_front());
                pops++;
            end
        end
        if (reset_n && bus.io_rden && !bus.io_read_EF) begin
            exp_uf = 1'b1;
        end
    end

    // Drive one cycle of stimulus starting just after a posedge; acc reports acceptance.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic rd,
                         output logic accepted);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.io_rden  = rd;
        @(negedge clock);
        accepted = v && bus.in_ready;
        @(posedge clock);
        if (accepted) begin
            exp_q.push_back(d);
        end
        #1;
        bus.in_valid = 1'b0;
        bus.io_rden  = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic apply_reset(input logic hold_valid, input logic [W-1:0] d);
        bus.io_rden  = 1'b0;
        bus.in_valid = hold_valid;
        bus.in_data  = d;
        reset_n      = 1'b0;
        exp_q.delete();
        exp_uf = 1'b0;
        #1;
        check("reset_now_EF", 64'(bus.io_read_EF), 64'(0));
        check("reset_now_in_ready", 64'(bus.in_ready), 64'(1));
        check("reset_now_data", 64'(bus.io_read_data), 64'(0));
        check("reset_now_underflow", 64'(bus.underflow), 64'(0));
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold_EF", 64'(bus.io_read_EF), 64'(0));
        check("reset_hold_in_ready", 64'(bus.in_ready), 64'(1));
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        reset_n      = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.io_rden  = 1'b0;

        // Reset with a word offered: nothing may be captured.
        apply_reset(1'b1, 36'h5);
        cycle(1'b0, '0, 1'b0, acc);
        check("post_reset_EF", 64'(bus.io_read_EF), 64'(0));

        // Single word fall-through and retire.
        cycle(1'b1, 36'd7, 1'b0, acc);
        check("single_acc", 64'(acc), 64'(1));
        check("single_EF", 64'(bus.io_read_EF), 64'(1));
        check("single_data", 64'(bus.io_read_data), 64'(7));
        cycle(1'b0, '0, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, acc);
        check("single_pop_EF", 64'(bus.io_read_EF), 64'(0));
        check("single_pop_data", 64'(bus.io_read_data), 64'(0));

        // Fill to full, hold a fifth word, free one slot, then drain.
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, W'(i), 1'b0, acc);
        end
        check("full_in_ready", 64'(bus.in_ready), 64'(0));
        check("full_head", 64'(bus.io_read_data), 64'(1));
        cycle(1'b1, 36'd5, 1'b0, acc);
        check("full_refuse", 64'(acc), 64'(0));
        cycle(1'b1, 36'd5, 1'b1, acc);
        check("full_pop_refuse", 64'(acc), 64'(0));
        check("full_pop_in_ready", 64'(bus.in_ready), 64'(1));
        check("full_pop_head", 64'(bus.io_read_data), 64'(2));
        cycle(1'b1, 36'd5, 1'b0, acc);
        check("full_retry_acc", 64'(acc), 64'(1));
        check("full_retry_in_ready", 64'(bus.in_ready), 64'(0));
        repeat (4) cycle(1'b0, '0, 1'b1, acc);
        check("drain_EF", 64'(bus.io_read_EF), 64'(0));

        // Simultaneous push and pop at count 2, then pop-only while full.
        cycle(1'b1, 36'd10, 1'b0, acc);
        cycle(1'b1, 36'd11, 1'b0, acc);
        cycle(1'b1, 36'd12, 1'b1, acc);
        check("pp_acc", 64'(acc), 64'(1));
        cycle(1'b1, 36'd13, 1'b1, acc);
        check("pp_head", 64'(bus.io_read_data), 64'(12));
        check("pp_in_ready", 64'(bus.in_ready), 64'(1));
        cycle(1'b1, 36'd14, 1'b0, acc);
        cycle(1'b1, 36'd15, 1'b0, acc);
        check("pp_full", 64'(bus.in_ready), 64'(0));
        cycle(1'b1, 36'd16, 1'b1, acc);
        check("full_pp_refuse", 64'(acc), 64'(0));
        check("full_pp_in_ready", 64'(bus.in_ready), 64'(1));
        check("full_pp_head", 64'(bus.io_read_data), 64'(13));
        repeat (3) cycle(1'b0, '0, 1'b1, acc);

        // Underflow is sticky until reset.
        cycle(1'b0, '0, 1'b1, acc);
        check("uf_set", 64'(bus.underflow), 64'(1));
        check("uf_EF", 64'(bus.io_read_EF), 64'(0));
        cycle(1'b1, 36'd20, 1'b1, acc);
        check("uf_push_acc", 64'(acc), 64'(1));
        check("uf_push_data", 64'(bus.io_read_data), 64'(20));
        cycle(1'b0, '0, 1'b1, acc);
        check("uf_sticky", 64'(bus.underflow), 64'(1));
        apply_reset(1'b0, '0);
        cycle(1'b0, '0, 1'b0, acc);
        check("uf_cleared", 64'(bus.underflow), 64'(0));

        // Stream 0..11 through the wrapping pointers with random read gaps.
        sent = 0;
        pops = 0;
        for (int c = 0; c < 200 && (sent < 12 || exp_q.size() != 0); c++) begin
            logic rd;
            rd = (sent >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle(sent < 12, W'(sent), rd, acc);
            if (acc) begin
                sent++;
            end
        end
        check("wrap_sent", 64'(sent), 64'(12));
        check("wrap_popped", 64'(pops), 64'(12));
        check("wrap_empty", 64'(exp_q.size()), 64'(0));

        // Reset mid-stream with three words held.
        cycle(1'b1, 36'd30, 1'b0, acc);
        cycle(1'b1, 36'd31, 1'b0, acc);
        cycle(1'b1, 36'd32, 1'b0, acc);
        check("mid_head", 64'(bus.io_read_data), 64'(30));
        apply_reset(1'b0, '0);
        cycle(1'b0, '0, 1'b0, acc);
        check("mid_after_EF", 64'(bus.io_read_EF), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/io_read_port_buffer.md
Name: io_read_port_buffer

Overview:
- Elastic input buffer for one Datapath I/O read port; one instance per port (IO_PORT_COUNT instances, concatenated by the parent).
- Sits directly upstream of Datapath: accepts words from an external producer via valid/ready and presents io_read_EF / io_read_data to Datapath.
- Retires the head word on io_rden.
- Decouples producer stalls from the Datapath's IO_ready thread-cancel logic.

Parameters:
- WORD_WIDTH, 36, width of data words.
- DEPTH, 4, buffer entries; power of two, minimum 2.
- ADDR_WIDTH, 2, log2(DEPTH); pointer width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  WORD_WIDTH  producer word.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  buffer can accept a word this cycle.
- io_read_EF  out  1  high = head word available (Datapath "ready" sense); low = empty.
- io_read_data  out  WORD_WIDTH  head word; zero when empty.
- io_rden  in  1  Datapath consumes the head word at this edge.
- underflow  out  1  sticky: io_rden seen while io_read_EF low.

Behaviour:
- Reset (async assert, sync-safe deassert): pointers=0, count=0, io_read_EF=0, in_ready=1, io_read_data=0, underflow=0.
- Storage: DEPTH x WORD_WIDTH registers; write pointer wp and read pointer rp wrap modulo DEPTH.
- count is ADDR_WIDTH+1 bits wide; full when count==DEPTH, empty when count==0.
- Push: in_valid & in_ready at an edge -> store at wp, wp+1.
- Pop: io_rden & io_read_EF at an edge -> rp+1.
- Flags are derived from registered count only, never from same-cycle inputs:
  - in_ready = (count != DEPTH)
  - io_read_EF = (count != 0)
- Latency: a word pushed at edge N is visible on io_read_data with io_read_EF=1 after edge N (first-word fall-through from registers). No bypass from in_data.
- io_read_data = storage[rp] when count!=0, else 0. Output is registered-source only, with no combinational path from in_*.
- Simultaneous push and pop while 0<count<DEPTH: count unchanged; both pointers advance.
- Full + in_valid + io_rden: pop only. The push is refused because in_ready=0; the producer holds and retries next cycle.
- Empty + io_rden: ignored, no pointer change, underflow set to 1. Cleared only by reset.
- Empty + in_valid + io_rden: push accepted, pop ignored, underflow set.
- Wrap-around: pointers roll over DEPTH-1 -> 0 without data loss across 3*DEPTH sequential words.
- Reset mid-operation: contents are discarded and state returns to reset values. Words already handed over via valid/ready are lost; upstream must tolerate this.
- No combinational path from io_rden to io_read_EF or in_ready.

Optional Feature:
- Macro IO_READ_BUFFER_COUNT_EN.
- Defined: adds output port fill_count [ADDR_WIDTH:0], the registered occupancy, reset 0, updating one cycle after each push/pop edge.
- Undefined: port absent; count logic still exists internally. Behaviour is otherwise identical.

Decomposition:
- Shared include, alongside the existing Datapath defines, holds:
  - default WORD_WIDTH;
  - the IO_READ_BUFFER_COUNT_EN guard;
  - a clog2-style constant function used to check ADDR_WIDTH==log2(DEPTH) at elaboration (error if mismatch or DEPTH<2).
- One sub-module, io_buffer_storage:
  - register-array storage, write port (wr_en, wr_addr, wr_data) and async read port (rd_addr -> rd_data);
  - pointer and flag logic stay in the top.

Test Plan:
- Reset check: hold reset_n=0 with in_valid=1 and in_data=36'h5 -> in_ready=1, io_read_EF=0, io_read_data=0, underflow=0; no push while reset is asserted.
- Single word: push 36'd7 at edge N -> io_read_EF=1 and io_read_data=7 after N; io_rden at N+2 -> io_read_EF=0, io_read_data=0 after N+2.
- Fill and full: push 1,2,3,4 with DEPTH=4 -> in_ready=0 after the 4th edge. A 5th word (5) held on in_valid stays unaccepted; one io_rden then returns 1 and the next edge accepts 5. Drain order is 2,3,4,5.
- Simultaneous push/pop at count=2: count stays 2 and the output sequence is preserved. Also assert io_rden together with in_valid at count=4 -> pop only, count=3.
- Underflow: io_rden=1 while empty -> underflow=1 and stays 1 through subsequent pushes/pops until reset_n pulses low.
- Wrap and reset: stream 0..11 with random io_rden gaps -> output exactly 0..11 in order. Assert reset_n low mid-stream at count=3 -> immediate io_read_EF=0 and in_ready=1. With IO_READ_BUFFER_COUNT_EN, fill_count tracks the reference model every cycle.
